// File: rtl/exc_ctrl_pkg.sv
// Shared types and constants for the exception sequencer.
// FSM encoding, CP0 register addresses, default exception vector.
package exc_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    REDIR = 2'd2
  } exc_state_e;

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC0_0380;

  localparam int CNT_W = 4;

  typedef struct packed {
    logic       ie;
    logic       exl;
    logic [1:0] im;
    logic [1:0] ip;
  } sw_int_t;

  function automatic logic sw_pend(input sw_int_t s);
    return |(s.im & s.ip);
  endfunction

endpackage

// File: rtl/exc_ctrl_int_sync.sv
// Two-flop synchronizer for asynchronous level inputs.
// Ports: clk, reset (sync, high), d[W-1:0] async in, q[W-1:0] synced out.
module int_sync #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer: arbitrates at WB commit, flushes the
// pipeline for FLUSH_CYCLES, then issues one redirect (vector or EPC).
// Ports: WB commit qualifiers, CP0 Status/Cause/EPC, redirect handshake;
// outputs interrupt/exception strobes, busy, flush, redirect_valid/pc.
// Optional: EXC_CTRL_HW_INT_EN adds hw_int[5:0], cp0_status_im_hw[5:0]
// inputs and hw_ip[5:0] output (synchronized hardware interrupts).
module exc_ctrl
  import exc_ctrl_pkg::*;
#(
  parameter int          FLUSH_CYCLES = 2,
  parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ready,
  input  logic        complete,
  input  logic        wb_valid,
  input  logic        wb_exchappen,
  input  logic        wb_eret,
  input  logic        cp0_status_ie,
  input  logic        cp0_status_exl,
  input  logic        cp0_status_im0,
  input  logic        cp0_status_im1,
  input  logic        cp0_cause_ip0,
  input  logic        cp0_cause_ip1,
  input  logic [31:0] cp0_epc_val,
  input  logic        redirect_ready,
`ifdef EXC_CTRL_HW_INT_EN
  input  logic [5:0]  hw_int,
  input  logic [5:0]  cp0_status_im_hw,
  output logic [5:0]  hw_ip,
`endif
  output logic        exception_inst_interrupt,
  output logic        exc_take,
  output logic        busy,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

  exc_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [31:0]      pc_q, pc_nxt;

  sw_int_t sw;
  logic    hw_pend;
  logic    int_pend;
  logic    commit;
  logic    accept;

  assign sw.ie  = cp0_status_ie;
  assign sw.exl = cp0_status_exl;
  assign sw.im  = {cp0_status_im1, cp0_status_im0};
  assign sw.ip  = {cp0_cause_ip1, cp0_cause_ip0};

`ifdef EXC_CTRL_HW_INT_EN
  logic [5:0] hw_sync;

  int_sync #(
    .W(6)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (hw_int),
    .q    (hw_sync)
  );

  assign hw_ip   = hw_sync;
  assign hw_pend = |(hw_sync & cp0_status_im_hw);
`else
  assign hw_pend = 1'b0;
`endif

  assign int_pend = sw.ie && !sw.exl && (sw_pend(sw) || hw_pend);

  // Commits are only honoured while idle; anything arriving while
  // busy is an instruction that is about to be flushed.
  assign commit = ready && complete && wb_valid && (state == IDLE);

  assign exception_inst_interrupt = commit && int_pend;
  assign exc_take = commit && !int_pend && (wb_exchappen || wb_eret);
  assign accept   = exception_inst_interrupt || exc_take;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      pc_q  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      pc_q  <= pc_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pc_nxt    = pc_q;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = FLUSH;
          cnt_nxt   = CNT_LOAD;
          // EPC is only the target for a bare ERET.
          if (exception_inst_interrupt || wb_exchappen)
            pc_nxt = EXC_VECTOR;
          else
            pc_nxt = cp0_epc_val;
        end
      end
      FLUSH: begin
        if (cnt == '0)
          state_nxt = REDIR;
        else
          cnt_nxt = cnt - 1'b1;
      end
      REDIR: begin
        if (redirect_ready)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy           = (state != IDLE);
  assign flush          = (state == FLUSH);
  assign redirect_valid = (state == REDIR);
  assign redirect_pc    = pc_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: vector table, directed sequences,
// and randomized traffic against a cycle-schedule reference model.
module tb_exc_ctrl;

  localparam int          FC  = 2;
  localparam logic [31:0] VEC = 32'hBFC0_0380;

  logic        clk = 1'b0;
  logic        reset;
  logic        ready, complete, wb_valid;
  logic        wb_exchappen, wb_eret;
  logic        ie, exl, im0, im1, ip0, ip1;
  logic [31:0] epc;
  logic        redirect_ready;
  logic        eii, exc_take, busy, flush, redirect_valid;
  logic [31:0] redirect_pc;
`ifdef EXC_CTRL_HW_INT_EN
  logic [5:0]  hw_int, im_hw, hw_ip;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  exc_ctrl #(
    .FLUSH_CYCLES(FC),
    .EXC_VECTOR  (VEC)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .ready                   (ready),
    .complete                (complete),
    .wb_valid                (wb_valid),
    .wb_exchappen            (wb_exchappen),
    .wb_eret                 (wb_eret),
    .cp0_status_ie           (ie),
    .cp0_status_exl          (exl),
    .cp0_status_im0          (im0),
    .cp0_status_im1          (im1),
    .cp0_cause_ip0           (ip0),
    .cp0_cause_ip1           (ip1),
    .cp0_epc_val             (epc),
    .redirect_ready          (redirect_ready),
`ifdef EXC_CTRL_HW_INT_EN
    .hw_int                  (hw_int),
    .cp0_status_im_hw        (im_hw),
    .hw_ip                   (hw_ip),
`endif
    .exception_inst_interrupt(eii),
    .exc_take                (exc_take),
    .busy                    (busy),
    .flush                   (flush),
    .redirect_valid          (redirect_valid),
    .redirect_pc             (redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clr_in();
    ready = 0; complete = 0; wb_valid = 0;
    wb_exchappen = 0; wb_eret = 0;
    ie = 0; exl = 0; im0 = 0; im1 = 0; ip0 = 0; ip1 = 0;
    epc = '0; redirect_ready = 0;
`ifdef EXC_CTRL_HW_INT_EN
    hw_int = '0; im_hw = '0;
`endif
  endtask

  task automatic do_reset();
    clr_in();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  task automatic set_commit(input logic v);
    ready = v; complete = v; wb_valid = v;
  endtask

  // After an accept edge: wait for redirect, report its pc, handshake.
  task automatic finish_event(output logic [31:0] pc);
    bit found = 0;
    pc = 'x;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (redirect_valid) begin
        found = 1;
        pc = redirect_pc;
      end else begin
        tick();
      end
    end
    chk("redirect_seen", 32'(found), 32'd1);
    redirect_ready = 1;
    tick();
    redirect_ready = 0;
  endtask

  typedef struct {
    string nm;
    logic  rdy, cmp, vld, exch, eret;
    logic  ie, exl, im0, im1, ip0, ip1;
    logic  e_int, e_take;
  } vec_t;

  vec_t tbl[$];

  // Reference model state: an event accepted at cycle acc_c is active
  // until its redirect handshake; outputs follow from cycle distance.
  bit          m_act;
  int          m_acc;
  logic [31:0] m_tgt;
`ifdef EXC_CTRL_HW_INT_EN
  logic [5:0]  h1, h2;
`endif

  initial begin
    logic [31:0] pc;
    reset = 1;
    clr_in();
    tick();
    tick();

    // reset state
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_flush", 32'(flush), 0);
    chk("rst_rv", 32'(redirect_valid), 0);
    chk("rst_pc", redirect_pc, 0);
    reset = 0;
    tick();

    tbl.push_back('{"exc",      1,1,1,1,0, 0,0,0,0,0,0, 0,1});
    tbl.push_back('{"eret",     1,1,1,0,1, 0,0,0,0,0,0, 0,1});
    tbl.push_back('{"exc_eret", 1,1,1,1,1, 0,0,0,0,0,0, 0,1});
    tbl.push_back('{"int1_exc", 1,1,1,1,0, 1,0,0,1,0,1, 1,0});
    tbl.push_back('{"exl_mask", 1,1,1,1,0, 1,1,0,1,0,1, 0,1});
    tbl.push_back('{"int0",     1,1,1,0,0, 1,0,1,0,1,0, 1,0});
    tbl.push_back('{"im0_off",  1,1,1,0,0, 1,0,0,0,1,0, 0,0});
    tbl.push_back('{"ie_off",   1,1,1,0,0, 0,0,1,1,1,1, 0,0});
    tbl.push_back('{"no_rdy",   0,1,1,1,0, 0,0,0,0,0,0, 0,0});
    tbl.push_back('{"no_cmp",   1,0,1,0,0, 1,0,1,0,1,0, 0,0});
    tbl.push_back('{"bubble",   1,1,0,0,0, 1,0,1,1,1,1, 0,0});
    tbl.push_back('{"ip_im_x",  1,1,1,0,0, 1,0,0,1,1,0, 0,0});

    foreach (tbl[i]) begin
      do_reset();
      ready = tbl[i].rdy; complete = tbl[i].cmp; wb_valid = tbl[i].vld;
      wb_exchappen = tbl[i].exch; wb_eret = tbl[i].eret;
      ie = tbl[i].ie; exl = tbl[i].exl;
      im0 = tbl[i].im0; im1 = tbl[i].im1;
      ip0 = tbl[i].ip0; ip1 = tbl[i].ip1;
      @(negedge clk);
      chk({"tbl_int_", tbl[i].nm}, 32'(eii), 32'(tbl[i].e_int));
      chk({"tbl_take_", tbl[i].nm}, 32'(exc_take), 32'(tbl[i].e_take));
    end

    // exception full timeline, second request during FLUSH ignored
    do_reset();
    set_commit(1); wb_exchappen = 1;
    @(negedge clk);
    chk("ex_take_T", 32'(exc_take), 1);
    tick();
    @(negedge clk);
    chk("ex_flush_T1", 32'(flush), 1);
    chk("ex_busy_T1", 32'(busy), 1);
    chk("ex_ignore_T1", 32'(exc_take), 0);
    tick();
    set_commit(0); wb_exchappen = 0;
    @(negedge clk);
    chk("ex_flush_T2", 32'(flush), 1);
    chk("ex_rv_T2", 32'(redirect_valid), 0);
    tick();
    @(negedge clk);
    chk("ex_flush_T3", 32'(flush), 0);
    chk("ex_rv_T3", 32'(redirect_valid), 1);
    chk("ex_pc_T3", redirect_pc, VEC);
    tick();
    redirect_ready = 1;
    @(negedge clk);
    chk("ex_rv_T4", 32'(redirect_valid), 1);
    tick();
    redirect_ready = 0;
    @(negedge clk);
    chk("ex_rv_T5", 32'(redirect_valid), 0);
    chk("ex_busy_T5", 32'(busy), 0);

    // ERET target held while EPC input changes
    do_reset();
    set_commit(1); wb_eret = 1; epc = 32'h8000_1234;
    tick();
    set_commit(0); wb_eret = 0; epc = '0;
    tick(); tick();
    @(negedge clk);
    chk("eret_pc_a", redirect_pc, 32'h8000_1234);
    tick();
    @(negedge clk);
    chk("eret_pc_b", redirect_pc, 32'h8000_1234);
    chk("eret_rv_b", 32'(redirect_valid), 1);

    // interrupt beats exception, goes to the vector
    do_reset();
    set_commit(1); wb_exchappen = 1; epc = 32'h1111_2222;
    ie = 1; im1 = 1; ip1 = 1;
    tick();
    set_commit(0); wb_exchappen = 0;
    finish_event(pc);
    chk("int_pc", pc, VEC);

    // interrupt held off by complete=0, taken when it rises
    do_reset();
    ready = 1; wb_valid = 1; ie = 1; im0 = 1; ip0 = 1;
    @(negedge clk);
    chk("stall_a", 32'(eii), 0);
    tick();
    @(negedge clk);
    chk("stall_b", 32'(eii), 0);
    tick();
    complete = 1;
    @(negedge clk);
    chk("stall_take", 32'(eii), 1);

    // reset during REDIR aborts the redirect
    do_reset();
    set_commit(1); wb_eret = 1; epc = 32'hDEAD_BEE0;
    tick();
    set_commit(0); wb_eret = 0;
    tick(); tick();
    @(negedge clk);
    chk("rr_in_redir", 32'(redirect_valid), 1);
    reset = 1;
    tick();
    reset = 0;
    @(negedge clk);
    chk("rr_rv", 32'(redirect_valid), 0);
    chk("rr_pc", redirect_pc, 0);
    chk("rr_flush", 32'(flush), 0);
    chk("rr_busy", 32'(busy), 0);

`ifdef EXC_CTRL_HW_INT_EN
    do_reset();
    tick();
    set_commit(1); ie = 1; im_hw = 6'b001000;
    hw_int = 6'b001000;
    @(negedge clk);
    chk("hw_c0", 32'(eii), 0);
    tick();
    @(negedge clk);
    chk("hw_c1", 32'(eii), 0);
    tick();
    @(negedge clk);
    chk("hw_c2", 32'(eii), 1);
    chk("hw_ip", 32'(hw_ip), 32'h08);
`endif

    // randomized traffic against the schedule model
    do_reset();
    m_act = 0;
`ifdef EXC_CTRL_HW_INT_EN
    h1 = '0; h2 = '0;
`endif
    for (int i = 0; i < 3000; i++) begin
      logic intp, cm, e_int, e_take, e_fl, e_rv;
      int d;
      ready = ($urandom_range(0, 3) != 0);
      complete = ($urandom_range(0, 3) != 0);
      wb_valid = ($urandom_range(0, 3) != 0);
      wb_exchappen = ($urandom_range(0, 9) < 3);
      wb_eret = ($urandom_range(0, 9) < 3);
      ie = ($urandom_range(0, 9) < 7);
      exl = ($urandom_range(0, 9) < 3);
      {im0, im1, ip0, ip1} = 4'($urandom);
      epc = $urandom;
      redirect_ready = $urandom_range(0, 1);
      reset = ($urandom_range(0, 99) == 0);
`ifdef EXC_CTRL_HW_INT_EN
      hw_int = 6'($urandom);
      im_hw = 6'($urandom);
`endif

      intp = ie && !exl && ((ip0 && im0) || (ip1 && im1));
`ifdef EXC_CTRL_HW_INT_EN
      intp = intp || (ie && !exl && ((h2 & im_hw) != 0));
`endif
      d = cyc - m_acc;
      e_fl = m_act && d <= FC;
      e_rv = m_act && d > FC;
      cm = !m_act && ready && complete && wb_valid;
      e_int = cm && intp;
      e_take = cm && !intp && (wb_exchappen || wb_eret);

      @(negedge clk);
      chk("rnd_int", 32'(eii), 32'(e_int));
      chk("rnd_take", 32'(exc_take), 32'(e_take));
      chk("rnd_busy", 32'(busy), 32'(m_act));
      chk("rnd_flush", 32'(flush), 32'(e_fl));
      chk("rnd_rv", 32'(redirect_valid), 32'(e_rv));
      if (e_rv) chk("rnd_pc", redirect_pc, m_tgt);
`ifdef EXC_CTRL_HW_INT_EN
      chk("rnd_hwip", 32'(hw_ip), 32'(h2));
      h2 = reset ? '0 : h1;
      h1 = reset ? '0 : hw_int;
`endif

      if (reset) begin
        m_act = 0;
      end else if (e_rv && redirect_ready) begin
        m_act = 0;
      end else if (e_int || e_take) begin
        m_act = 1;
        m_acc = cyc;
        m_tgt = (e_int || wb_exchappen) ? VEC : epc;
      end
      tick();
    end
    reset = 0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
